freq_duty_calc: RTL and testbench

- Sits directly downstream of the period-measurement stage in COMPUTATION.
- Consumes the measured high-time count (PERIOD1), the total-period count (PERIOD2) and the one-cycle PERIOD_FLAG strobe.
- Converts them to signal frequency in Hz and duty cycle in whole percent, using one shared serial restoring divider (one quotient bit per clock).
- Results go to the display/measurement readout path.

---
 rtl/freq_duty_if.sv | 15 +
 rtl/freq_duty_calc.sv | 81 ++++++++
 tb/tb_freq_duty_calc.sv | 124 ++++++++++++
 3 files changed

// File: rtl/freq_duty_if.sv
// freq_duty_if: measured-period operands in, frequency/duty results out.
interface freq_duty_if #(parameter int PER_W = 25);
    logic [PER_W-1:0] PERIOD1;
    logic [PER_W-1:0] PERIOD2;
    logic             PERIOD_FLAG;
    logic [31:0]      FREQ;
    logic [6:0]       DUTY;
    logic             DIV_ERR;
    logic             RESULT_VALID;
    logic             BUSY;
    modport master(output PERIOD1, PERIOD2, PERIOD_FLAG,
                   input FREQ, DUTY, DIV_ERR, RESULT_VALID, BUSY);
    modport slave(input PERIOD1, PERIOD2, PERIOD_FLAG,
                  output FREQ, DUTY, DIV_ERR, RESULT_VALID, BUSY);
endinterface

// File: rtl/freq_duty_calc.sv
// freq_duty_calc: frequency and duty from period counts via one shared serial divider.
// Optional FREQ_DUTY_OVERRUN_EN adds OVERRUN_CNT, counting flags dropped while busy.
module freq_duty_calc #(
    parameter logic [31:0] CLK_HZ = 32'd50_000_000,
    parameter int          PER_W  = 25
) (
    input logic        CLK,
    input logic        RST,
    freq_duty_if.slave io
`ifdef FREQ_DUTY_OVERRUN_EN
    ,
    output logic [7:0] OVERRUN_CNT
`endif
);
    typedef enum logic [2:0] {IDLE, DIV_F, LD_D, DIV_D, DONE} state_t;
    state_t state, nxt;
    logic [PER_W-1:0] p1, p2;
    logic [32:0] rem, rem_sh;
    logic [31:0] q, fq;
    logic [4:0] cnt;
    logic ge, zero_div;
    always_ff @(posedge CLK) state <= RST ? IDLE : nxt;
    always_comb begin
        nxt = state == IDLE  ? (io.PERIOD_FLAG ? DIV_F : IDLE) :
              state == DIV_F ? (cnt == 5'd31 ? LD_D : DIV_F) :
              state == LD_D  ? DIV_D :
              state == DIV_D ? (cnt == 5'd31 ? DONE : DIV_D) : IDLE;
        rem_sh = {rem[31:0], q[31]};
        ge = rem_sh >= {{(33-PER_W){1'b0}}, p2};
        zero_div = p2 == '0;
    end
    assign io.BUSY = state != IDLE;
    // q holds the dividend and shifts quotient bits in from the bottom
    always_ff @(posedge CLK) begin
        if (RST) begin
            p1 <= '0;
            p2 <= '0;
            rem <= '0;
            q <= '0;
            fq <= '0;
            cnt <= '0;
            io.FREQ <= '0;
            io.DUTY <= '0;
            io.DIV_ERR <= 1'b0;
            io.RESULT_VALID <= 1'b0;
        end else begin
            io.RESULT_VALID <= 1'b0;
            case (state)
                IDLE: if (io.PERIOD_FLAG) begin
                    p1 <= io.PERIOD1;
                    p2 <= io.PERIOD2;
                    q <= CLK_HZ;
                    rem <= '0;
                    cnt <= '0;
                end
                DIV_F, DIV_D: begin
                    rem <= ge ? rem_sh - {{(33-PER_W){1'b0}}, p2} : rem_sh;
                    q <= {q[30:0], ge};
                    cnt <= cnt + 5'd1;
                end
                LD_D: begin
                    fq <= q;
                    q <= 32'(p1) * 32'd100;
                    rem <= '0;
                    cnt <= '0;
                end
                default: begin
                    io.FREQ <= zero_div ? 32'd0 : fq;
                    io.DUTY <= zero_div ? 7'd0 : q > 32'd100 ? 7'd100 : q[6:0];
                    io.DIV_ERR <= zero_div;
                    io.RESULT_VALID <= 1'b1;
                end
            endcase
        end
    end
`ifdef FREQ_DUTY_OVERRUN_EN
    always_ff @(posedge CLK)
        if (RST) OVERRUN_CNT <= '0;
        else if (io.PERIOD_FLAG && io.BUSY && OVERRUN_CNT != 8'hff) OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
`endif
endmodule

// File: tb/tb_freq_duty_calc.sv
// tb_freq_duty_calc: scoreboard bench, expected results queued at issue, checked on RESULT_VALID.
module tb_freq_duty_calc;
    logic CLK = 0;
    logic RST = 1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    typedef struct {longint f; longint d; longint e; int c;} exp_t;
    exp_t sb[$];
    freq_duty_if #(.PER_W(25)) io();
`ifdef FREQ_DUTY_OVERRUN_EN
    logic [7:0] ovr;
`endif
    freq_duty_calc #(.CLK_HZ(32'd50_000_000), .PER_W(25)) dut (
        .CLK(CLK),
        .RST(RST),
        .io(io)
`ifdef FREQ_DUTY_OVERRUN_EN
        ,
        .OVERRUN_CNT(ovr)
`endif
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    always @(negedge CLK) if (io.RESULT_VALID) begin
        chk("expected_result", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("freq", io.FREQ, e.f);
            chk("duty", io.DUTY, e.d);
            chk("div_err", io.DIV_ERR, e.e);
            chk("latency", cyc, e.c);
            chk("busy_at_valid", io.BUSY, 0);
        end
    end
    task automatic issue(input int p1, input int p2, input bit acc);
        exp_t e;
        io.PERIOD1 = 25'(p1);
        io.PERIOD2 = 25'(p2);
        io.PERIOD_FLAG = 1;
        @(posedge CLK);
        #1;
        if (acc) begin
            e.e = (p2 == 0);
            e.f = (p2 == 0) ? 0 : 64'd50_000_000 / longint'(p2);
            e.d = (p2 == 0) ? 0 : longint'(p1) * 100 / longint'(p2);
            if (e.d > 100) e.d = 100;
            e.c = cyc + 66;
            sb.push_back(e);
        end
        @(negedge CLK);
        io.PERIOD_FLAG = 0;
    endtask
    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
        chk("drain", sb.size(), 0);
        @(negedge CLK);
    endtask
    task automatic run(input int p1, input int p2);
        @(negedge CLK);
        issue(p1, p2, 1);
        chk("busy_after_flag", io.BUSY, 1);
        drain();
    endtask
    initial begin
        io.PERIOD1 = 0;
        io.PERIOD2 = 0;
        io.PERIOD_FLAG = 0;
        repeat (3) @(negedge CLK);
        RST = 0;
        chk("rst_freq", io.FREQ, 0);
        chk("rst_duty", io.DUTY, 0);
        chk("rst_err", io.DIV_ERR, 0);
        chk("rst_valid", io.RESULT_VALID, 0);
        chk("rst_busy", io.BUSY, 0);
        run(25000, 50000);
        run(1, 3);
        run(1, 1);
        run(60000, 50000);
        run(10, 0);
        run(25000, 50000);
        run(33_554_431, 1);
        for (int i = 0; i < 4; i++) run($urandom_range(0, 2_000_000), $urandom_range(1, 3_000_000));
        @(negedge CLK);
        issue(25000, 50000, 1);
        repeat (8) @(negedge CLK);
        issue(7, 9, 0);
        drain();
`ifdef FREQ_DUTY_OVERRUN_EN
        chk("overrun_cnt", ovr, 1);
`endif
        @(negedge CLK);
        issue(3, 4, 1);
        for (int i = 0; i < 100 && !io.RESULT_VALID; i++) @(negedge CLK);
        issue(1, 5, 1);
        drain();
        @(negedge CLK);
        issue(1234, 5000, 0);
        repeat (28) @(negedge CLK);
        RST = 1;
        @(negedge CLK);
        RST = 0;
        chk("abort_freq", io.FREQ, 0);
        chk("abort_duty", io.DUTY, 0);
        chk("abort_err", io.DIV_ERR, 0);
        chk("abort_valid", io.RESULT_VALID, 0);
        chk("abort_busy", io.BUSY, 0);
`ifdef FREQ_DUTY_OVERRUN_EN
        chk("abort_overrun", ovr, 0);
`endif
        repeat (80) @(negedge CLK);
        run(25000, 50000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
